// File: rtl/gf180mcu_osu_sc_12t_subf_serial.sv
// Bit-serial full subtractor: DIFF = A - B - BI computed LSB first over WIDTH cycles
// using a single full-subtractor slice and a registered borrow.
module gf180mcu_osu_sc_12t_subf_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    input  logic             ACK,
    output logic             BUSY,
    output logic             SV,
    output logic             SD,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BO
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  areg;
    logic [WIDTH-1:0]  breg;
    logic              borrow;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH-1:0]  diff_q;
    logic              bo_q;
    logic              busy_q;
    logic              sv_q;
    logic              done_q;
    logic              d_c;
    logic              bnext_c;
    logic              last_c;

    // Full-subtractor slice on the registered operand LSBs
    assign d_c     = areg[0] ^ breg[0] ^ borrow;
    assign bnext_c = (~areg[0] & breg[0]) | (~areg[0] & borrow) | (breg[0] & borrow);
    assign last_c  = (cnt == CNTW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START)  state_d = S_RUN;
            S_RUN:  if (last_c) state_d = S_DONE;
            S_DONE: if (ACK)    state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // State register plus registered status flags decoded from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            sv_q    <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Datapath: load on accepted START, shift one bit per RUN cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            areg   <= '0;
            breg   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        areg   <= A;
                        breg   <= B;
                        borrow <= BI;
                        cnt    <= '0;
                        diff_q <= '0;
                        bo_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    diff_q <= {d_c, diff_q[WIDTH-1:1]};
                    borrow <= bnext_c;
                    cnt    <= cnt + CNTW'(1);
                    if (last_c) bo_q <= bnext_c;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = busy_q;
    assign SV   = sv_q;
    assign SD   = sv_q & d_c;
    assign DONE = done_q;
    assign DIFF = diff_q;
    assign BO   = bo_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_subf_serial.sv
// Directed and random checks of the serial subtractor at WIDTH = 8, 2 and 32,
// all three instances sharing one clock and handshake.
module tb_gf180mcu_osu_sc_12t_subf_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        bi_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        busy8, sv8, sd8, done8, bo8;
    logic [7:0]  diff8;
    logic        busy2, sv2, sd2, done2, bo2;
    logic [1:0]  diff2;
    logic        busy32, sv32, sd32, done32, bo32;
    logic [31:0] diff32;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gf180mcu_osu_sc_12t_subf_serial #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start), .A(a_in[7:0]), .B(b_in[7:0]), .BI(bi_in),
        .ACK(ack), .BUSY(busy8), .SV(sv8), .SD(sd8), .DONE(done8), .DIFF(diff8), .BO(bo8)
    );

    gf180mcu_osu_sc_12t_subf_serial #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST(rst), .START(start), .A(a_in[1:0]), .B(b_in[1:0]), .BI(bi_in),
        .ACK(ack), .BUSY(busy2), .SV(sv2), .SD(sd2), .DONE(done2), .DIFF(diff2), .BO(bo2)
    );

    gf180mcu_osu_sc_12t_subf_serial #(.WIDTH(32)) dut32 (
        .CLK(clk), .RST(rst), .START(start), .A(a_in), .B(b_in), .BI(bi_in),
        .ACK(ack), .BUSY(busy32), .SV(sv32), .SD(sd32), .DONE(done32), .DIFF(diff32), .BO(bo32)
    );

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
        a_in  = a;
        b_in  = b;
        bi_in = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done8(input string tag);
        int n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done_wait"}, 64'(done8), 64'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Full 8-bit operation with serial stream, latency and result checks
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input string tag);
        logic [7:0] sdv;
        int         svn;
        sdv = '0;
        svn = 0;
        start_op({24'h0, a}, {24'h0, b}, bi);
        for (int i = 0; i < 8; i++) begin
            if (sv8 && busy8 && !done8) svn++;
            sdv[i] = sd8;
            tick();
        end
        chk({tag, "_sv_cycles"}, 64'(svn), 64'd8);
        chk({tag, "_sd_stream"}, 64'(sdv), 64'(ed));
        chk({tag, "_done"}, 64'(done8), 64'd1);
        chk({tag, "_sv_off"}, 64'(sv8), 64'd0);
        chk({tag, "_diff"}, 64'(diff8), 64'(ed));
        chk({tag, "_bo"}, 64'(bo8), 64'(eb));
    endtask

    initial begin
        logic [32:0] r32;
        logic [8:0]  r8;
        logic [2:0]  r2;
        int          n;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_outs8", {busy8, sv8, sd8, done8, bo8, diff8}, '0);
        chk("rst_outs2", {busy2, sv2, sd2, done2, bo2, diff2}, '0);
        chk("rst_outs32", {busy32, sv32, sd32, done32, bo32, diff32}, '0);

        // Basic subtraction
        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "t1");
        do_ack();
        chk("t1_ack_idle", {busy8, done8}, 64'd0);

        // Negative result, DONE held while ACK stays low
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "t2");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold", {done8, busy8, bo8, diff8}, {3'b111, 8'hFE});
        end
        do_ack();
        chk("t2_after_ack", {done8, busy8, bo8, diff8}, {3'b001, 8'hFE});
        tick();

        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "t3a");
        do_ack();
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3b");
        do_ack();
        op8(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, "t3c");
        do_ack();

        // START during RUN and DONE is ignored
        start_op(32'h40, 32'h10, 1'b0);
        tick();
        tick();
        tick();
        a_in  = 32'hAA;
        b_in  = 32'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done8("t4");
        chk("t4_diff", 64'(diff8), 64'h30);
        chk("t4_bo", 64'(bo8), 64'd0);
        a_in  = 32'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_done_start", {done8, busy8, bo8, diff8}, {3'b110, 8'h30});
        do_ack();

        // Reset mid-RUN discards the partial result
        start_op(32'h55, 32'h22, 1'b0);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_outs", {busy8, sv8, sd8, done8, bo8, diff8}, '0);
        op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "t5");

        // ACK with START in DONE: IDLE only; START held next cycle is accepted
        a_in  = 32'h20;
        b_in  = 32'h05;
        bi_in = 1'b0;
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        chk("t6_idle_only", {busy8, sv8, done8}, 64'd0);
        op8(8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, "t6");
        do_ack();

        // Random sweep, all three widths in lockstep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int v = 0; v < 1000; v++) begin
            start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
            n = 0;
            while (!(done8 && done2 && done32) && n < 40) begin
                tick();
                n++;
            end
            r32 = {1'b0, a_in} - {1'b0, b_in} - 33'(bi_in);
            r8  = {1'b0, a_in[7:0]} - {1'b0, b_in[7:0]} - 9'(bi_in);
            r2  = {1'b0, a_in[1:0]} - {1'b0, b_in[1:0]} - 3'(bi_in);
            chk("sweep_done", {done2, done8, done32}, 64'd7);
            chk("sweep_w8", {bo8, diff8}, 64'(r8));
            chk("sweep_w2", {bo2, diff2}, 64'(r2));
            chk("sweep_w32", {bo32, diff32}, 64'(r32));
            do_ack();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
